// File: rtl/vx_perf_pkg.sv
// vx_perf_pkg: shared definitions for the pipeline performance-counter bank.
//   PERF_CTR_BITS  - default counter width
//   PERF_NUM_CTRS  - number of counters in the standard pipeline bank
//   perf_ctr_e     - counter index assignment (read address of each event)
//   rd_state_e     - read-port FSM states
//   perf_ovf       - helper: carry-out of an extended counter sum
package vx_perf_pkg;

    localparam int PERF_CTR_BITS = 44;
    localparam int PERF_NUM_CTRS = 12;

    typedef enum logic [3:0] {
        SCHED_IDLES    = 4'd0,
        SCHED_STALLS   = 4'd1,
        IBF_STALLS     = 4'd2,
        NOCU_STALLS    = 4'd3,
        RF_READS       = 4'd4,
        RF_WRITES      = 4'd5,
        REORDERS       = 4'd6,
        IFETCHES       = 4'd7,
        LOADS          = 4'd8,
        STORES         = 4'd9,
        IFETCH_LATENCY = 4'd10,
        LOAD_LATENCY   = 4'd11
    } perf_ctr_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    // The sum is computed one bit wider than the counter; its top bit is the carry.
    function automatic logic perf_ovf(input logic [PERF_CTR_BITS:0] sum, input int ctr_w);
        return sum[ctr_w];
    endfunction

endpackage

// File: rtl/vx_perf_ctr.sv
// vx_perf_ctr: one event counter with per-cycle increment, synchronous clear,
// sticky overflow flag and wrap/saturate selection.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : increments ignored when low
//   clear      : zeroes counter and overflow flag, wins over the increment
//   inc        : event count for this cycle (zero-extended into the sum)
//   cnt, ovf   : registered counter value and sticky overflow flag
// Optional feature macro of the enclosing bank: VX_PERF_SNAPSHOT_EN (not used here).
module vx_perf_ctr
    import vx_perf_pkg::*;
#(
    parameter int CTR_W    = PERF_CTR_BITS,
    parameter int INC_W    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [INC_W-1:0] inc,
    output logic [CTR_W-1:0] cnt,
    output logic             ovf
);

    logic [CTR_W-1:0] cnt_r;
    logic             ovf_r;
    logic [CTR_W:0]   sum_s;
    logic [CTR_W-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;

    assign sum_s = {1'b0, cnt_r} + {{(CTR_W + 1 - INC_W){1'b0}}, inc};

    // Next-state: clear first, then overflow-aware increment.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = ovf_r;
        if (clear) begin
            cnt_nxt_s = {CTR_W{1'b0}};
            ovf_nxt_s = 1'b0;
        end else if (enable) begin
            if (sum_s[CTR_W]) begin
                ovf_nxt_s = 1'b1;
                if (SATURATE != 0) begin
                    cnt_nxt_s = {CTR_W{1'b1}};
                end else begin
                    cnt_nxt_s = sum_s[CTR_W-1:0];
                end
            end else begin
                cnt_nxt_s = sum_s[CTR_W-1:0];
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CTR_W{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_nxt_s;
        end
    end

    assign cnt = cnt_r;
    assign ovf = ovf_r;

endmodule

// File: rtl/vx_perf_ctr_bank.sv
// vx_perf_ctr_bank: parametrised bank of pipeline performance counters with a
// valid/ready read port (one read per two cycles, one-cycle response latency).
//   clk, reset          : clock, asynchronous active-high reset
//   enable, clear       : counting enable, synchronous clear of counters/flags/shadows
//   inc_amt             : per-counter event counts, counter i uses [i*INC_W +: INC_W]
//   snap_req, snap_done : snapshot request pulse, completion pulse one cycle later
//   req_valid/ready/addr: read request handshake and counter index
//   rsp_valid/ready     : read response handshake
//   rsp_data, rsp_ovf   : counter value and sticky overflow flag of the read counter
// Optional feature macro: VX_PERF_SNAPSHOT_EN. When defined, reads return shadow
// registers captured by snap_req; otherwise reads sample the live counter at
// accept, snap_req is ignored and snap_done stays 0.
module vx_perf_ctr_bank
    import vx_perf_pkg::*;
#(
    parameter int NUM_CTRS = PERF_NUM_CTRS,
    parameter int CTR_W    = PERF_CTR_BITS,
    parameter int INC_W    = 4,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [NUM_CTRS*INC_W-1:0]   inc_amt,
    input  logic                        snap_req,
    output logic                        snap_done,
    input  logic                        req_valid,
    input  logic [$clog2(NUM_CTRS)-1:0] req_addr,
    output logic                        req_ready,
    output logic                        rsp_valid,
    output logic [CTR_W-1:0]            rsp_data,
    output logic                        rsp_ovf,
    input  logic                        rsp_ready
);

    logic [CTR_W-1:0] cnt_s    [NUM_CTRS];
    logic [CTR_W-1:0] rd_src_s [NUM_CTRS];
    logic [NUM_CTRS-1:0] ovf_s;

    for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
        vx_perf_ctr #(
            .CTR_W    (CTR_W),
            .INC_W    (INC_W),
            .SATURATE (SATURATE)
        ) u_ctr (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .clear  (clear),
            .inc    (inc_amt[g*INC_W +: INC_W]),
            .cnt    (cnt_s[g]),
            .ovf    (ovf_s[g])
        );
    end

`ifdef VX_PERF_SNAPSHOT_EN
    logic [CTR_W-1:0] shadow_r [NUM_CTRS];
    logic             snap_done_r;

    // Shadow capture of pre-update counts; a coincident clear captures zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow_r[i] <= {CTR_W{1'b0}};
            end
            snap_done_r <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow_r[i] <= {CTR_W{1'b0}};
            end
            snap_done_r <= snap_req;
        end else if (snap_req) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
                shadow_r[i] <= cnt_s[i];
            end
            snap_done_r <= 1'b1;
        end else begin
            snap_done_r <= 1'b0;
        end
    end

    assign rd_src_s  = shadow_r;
    assign snap_done = snap_done_r;
`else
    logic unused_snap_req_s;

    assign unused_snap_req_s = snap_req;
    assign rd_src_s          = cnt_s;
    assign snap_done         = 1'b0;
`endif

    logic [CTR_W-1:0] rd_data_s;
    logic             rd_ovf_s;

    // Addressed read source; indices beyond the bank read as zero.
    always_comb begin
        rd_data_s = {CTR_W{1'b0}};
        rd_ovf_s  = 1'b0;
        if (int'(req_addr) < NUM_CTRS) begin
            rd_data_s = rd_src_s[req_addr];
            rd_ovf_s  = ovf_s[req_addr];
        end else begin
            rd_data_s = {CTR_W{1'b0}};
            rd_ovf_s  = 1'b0;
        end
    end

    rd_state_e        state_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [CTR_W-1:0] rsp_data_r;
    logic             rsp_ovf_r;

    // Read FSM: accept in IDLE, hold the registered response in RESP until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RD_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {CTR_W{1'b0}};
            rsp_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                RD_IDLE: begin
                    if (req_valid) begin
                        state_r     <= RD_RESP;
                        req_ready_r <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= rd_data_s;
                        rsp_ovf_r   <= rd_ovf_s;
                    end else begin
                        state_r <= RD_IDLE;
                    end
                end
                RD_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= RD_IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        state_r <= RD_RESP;
                    end
                end
                default: begin
                    state_r     <= RD_IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_ovf   = rsp_ovf_r;

endmodule

// File: tb/tb_vx_perf_ctr_bank.sv
// Directed bench for vx_perf_ctr_bank. Three instances share one stimulus:
// the default 44-bit wrap bank, plus 8-bit wrap and 8-bit saturate banks used
// for the overflow boundaries. Works with or without VX_PERF_SNAPSHOT_EN.
module tb_vx_perf_ctr_bank;

    localparam int N     = 12;
    localparam int INC_W = 4;
`ifdef VX_PERF_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, enable, clear, snap_req, req_valid, rsp_ready;
    logic [N*INC_W-1:0] inc_amt;
    logic [3:0]       req_addr;

    logic        m_snap_done, m_req_ready, m_rsp_valid, m_rsp_ovf;
    logic [43:0] m_rsp_data;
    logic        w_snap_done, w_req_ready, w_rsp_valid, w_rsp_ovf;
    logic [7:0]  w_rsp_data;
    logic        s_snap_done, s_req_ready, s_rsp_valid, s_rsp_ovf;
    logic [7:0]  s_rsp_data;

    vx_perf_ctr_bank #(.NUM_CTRS(N), .CTR_W(44), .INC_W(INC_W), .SATURATE(0)) u_main (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inc_amt(inc_amt),
        .snap_req(snap_req), .snap_done(m_snap_done), .req_valid(req_valid),
        .req_addr(req_addr), .req_ready(m_req_ready), .rsp_valid(m_rsp_valid),
        .rsp_data(m_rsp_data), .rsp_ovf(m_rsp_ovf), .rsp_ready(rsp_ready));

    vx_perf_ctr_bank #(.NUM_CTRS(N), .CTR_W(8), .INC_W(INC_W), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inc_amt(inc_amt),
        .snap_req(snap_req), .snap_done(w_snap_done), .req_valid(req_valid),
        .req_addr(req_addr), .req_ready(w_req_ready), .rsp_valid(w_rsp_valid),
        .rsp_data(w_rsp_data), .rsp_ovf(w_rsp_ovf), .rsp_ready(rsp_ready));

    vx_perf_ctr_bank #(.NUM_CTRS(N), .CTR_W(8), .INC_W(INC_W), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .inc_amt(inc_amt),
        .snap_req(snap_req), .snap_done(s_snap_done), .req_valid(req_valid),
        .req_addr(req_addr), .req_ready(s_req_ready), .rsp_valid(s_rsp_valid),
        .rsp_data(s_rsp_data), .rsp_ovf(s_rsp_ovf), .rsp_ready(rsp_ready));

    int total = 0;
    int bad   = 0;
    int snap_hi_cnt = 0;

    logic [43:0] rd_m;
    logic [7:0]  rd_w, rd_s;
    logic        ro_m, ro_w, ro_s;

    always @(posedge m_snap_done) snap_hi_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inc(input int idx, input logic [3:0] v);
        inc_amt[idx*INC_W +: INC_W] = v;
    endtask

    // Optional snapshot, then one full read handshake on all three banks.
    task automatic rd(input logic [3:0] addr, input bit do_snap);
        if (do_snap) begin
            snap_req = 1'b1;
            step();
            chk("snap_done_pulse", 64'(m_snap_done), 64'(SNAP_EN));
            snap_req = 1'b0;
        end
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        chk("rsp_valid_latency", 64'(m_rsp_valid), 64'd1);
        chk("req_ready_in_resp", 64'(m_req_ready), 64'd0);
        if (do_snap) chk("snap_done_one_cycle", 64'(m_snap_done), 64'd0);
        req_valid = 1'b0;
        rd_m = m_rsp_data; ro_m = m_rsp_ovf;
        rd_w = w_rsp_data; ro_w = w_rsp_ovf;
        rd_s = s_rsp_data; ro_s = s_rsp_ovf;
        rsp_ready = 1'b1;
        step();
        chk("rsp_valid_drop", 64'(m_rsp_valid), 64'd0);
        chk("req_ready_back", 64'(m_req_ready), 64'd1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; snap_req = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0; req_addr = 4'd0; inc_amt = '0;
        step(); step();
        chk("reset_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(m_rsp_data), 64'd0);
        chk("reset_rsp_ovf", 64'(m_rsp_ovf), 64'd0);
        chk("reset_snap_done", 64'(m_snap_done), 64'd0);
        chk("reset_req_ready", 64'(m_req_ready), 64'd1);
        reset = 1'b0; enable = 1'b1;
        step();

        // 5 events per cycle on counter 3 for 4 cycles -> 20.
        set_inc(3, 4'd5);
        repeat (4) step();
        inc_amt = '0;
        rd(4'd3, 1'b1);
        chk("ctr3_sum", 64'(rd_m), 64'd20);
        chk("ctr3_ovf", 64'(ro_m), 64'd0);

        // Clear beats a same-cycle increment; coincident snapshot captures zero.
        set_inc(0, 4'd7);
        step();
        clear = 1'b1; snap_req = 1'b1;
        step();
        chk("clear_snap_done", 64'(m_snap_done), 64'(SNAP_EN));
        clear = 1'b0; snap_req = 1'b0; inc_amt = '0;
        rd(4'd0, 1'b0);
        chk("clear_beats_inc", 64'(rd_m), 64'd0);
        chk("clear_ovf", 64'(ro_m), 64'd0);
        rd(4'd3, 1'b0);
        chk("clear_all_ctrs", 64'(rd_m), 64'd0);

        // Counter 1 up to 255 exactly (no overflow yet).
        set_inc(1, 4'd15);
        repeat (16) step();
        set_inc(1, 4'd10);
        step();
        set_inc(1, 4'd5);
        step();
        inc_amt = '0;
        rd(4'd1, 1'b1);
        chk("w_255", 64'(rd_w), 64'd255);
        chk("w_255_ovf", 64'(ro_w), 64'd0);
        chk("s_255", 64'(rd_s), 64'd255);
        chk("s_255_ovf", 64'(ro_s), 64'd0);

        // +10 -> 265: wraps to 9 / clamps at 255, both flag overflow.
        set_inc(1, 4'd10);
        step();
        inc_amt = '0;
        rd(4'd1, 1'b1);
        chk("m_265", 64'(rd_m), 64'd265);
        chk("m_265_ovf", 64'(ro_m), 64'd0);
        chk("w_wrap", 64'(rd_w), 64'd9);
        chk("w_wrap_ovf", 64'(ro_w), 64'd1);
        chk("s_clamp", 64'(rd_s), 64'd255);
        chk("s_clamp_ovf", 64'(ro_s), 64'd1);

        // +30 more: wrap keeps counting, saturate stays put, flags sticky.
        set_inc(1, 4'd15);
        repeat (2) step();
        inc_amt = '0;
        rd(4'd1, 1'b1);
        chk("m_295", 64'(rd_m), 64'd295);
        chk("w_39", 64'(rd_w), 64'd39);
        chk("w_sticky", 64'(ro_w), 64'd1);
        chk("s_stays", 64'(rd_s), 64'd255);
        chk("s_sticky", 64'(ro_s), 64'd1);

        // Back-pressure: response held for 5 cycles across snap, increment and clear.
        req_valid = 1'b1; req_addr = 4'd1;
        step();
        chk("hold_accept", 64'(m_rsp_valid), 64'd1);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin set_inc(1, 4'd3); snap_req = 1'b1; end
            if (k == 3) clear = 1'b1;
            step();
            inc_amt = '0; snap_req = 1'b0; clear = 1'b0;
            if (k == 1) chk("hold_snap_done", 64'(m_snap_done), 64'(SNAP_EN));
            chk("hold_rsp_valid", 64'(m_rsp_valid), 64'd1);
            chk("hold_rsp_data", 64'(m_rsp_data), 64'd295);
            chk("hold_req_ready", 64'(m_req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("release_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("release_req_ready", 64'(m_req_ready), 64'd1);
        rsp_ready = 1'b0;
        rd(4'd1, 1'b1);
        chk("after_hold_clear", 64'(rd_m), 64'd0);
        chk("after_hold_w_ovf", 64'(ro_w), 64'd0);

        // Address boundaries: last valid index vs one past the end.
        inc_amt = {N{4'h1}};
        repeat (3) step();
        inc_amt = '0;
        rd(4'd11, 1'b1);
        chk("addr_last", 64'(rd_m), 64'd3);
        rd(4'd12, 1'b1);
        chk("addr_oob_data", 64'(rd_m), 64'd0);
        chk("addr_oob_ovf", 64'(ro_m), 64'd0);

        // Asynchronous reset while a response is pending.
        req_valid = 1'b1; req_addr = 4'd11;
        step();
        chk("pre_reset_data", 64'(m_rsp_data), 64'd3);
        req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rsp_valid", 64'(m_rsp_valid), 64'd0);
        chk("async_rsp_data", 64'(m_rsp_data), 64'd0);
        step();
        reset = 1'b0;
        step();

        // No snapshot: live read sees 20; with snapshot the shadow is still 0.
        set_inc(5, 4'd2);
        repeat (10) step();
        inc_amt = '0;
        rd(4'd5, 1'b0);
        chk("live_read_ctr5", 64'(rd_m), SNAP_EN ? 64'd0 : 64'd20);
        chk("snap_done_activity", 64'(snap_hi_cnt != 0), 64'(SNAP_EN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_perf_ctr_bank.md
Name: vx_perf_ctr_bank

Overview:
Parametrised pipeline performance-counter bank, successor to the fixed pipeline perf interface.
- Accumulates NUM_CTRS event counters; each input is a per-cycle event count, not a pre-counted value.
- Supports wrap or saturate, sticky overflow, global clear, and atomic snapshot.
- Counters are read through a valid/ready request/response port.
- Sits beside schedule/issue/LSU; feeds the CSR/DCR perf readout path.

Parameters:
NUM_CTRS, 12, number of counters (indices per package enum).
CTR_W, 44, counter width (PERF_CTR_BITS).
INC_W, 4, width of per-cycle increment per counter.
SATURATE, 0, 0 = wrap on overflow, 1 = clamp at all-ones.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous active-high reset.
enable  in  1  counting enable; when 0, increments are ignored.
clear  in  1  synchronous pulse; zeroes all counters, overflow flags and snapshot.
inc_amt  in  NUM_CTRS*INC_W  per-counter increment this cycle; counter i uses slice [i*INC_W +: INC_W].
snap_req  in  1  pulse; captures all live counters into the shadow registers.
snap_done  out  1  one-cycle pulse, the cycle after capture.
req_valid  in  1  read request valid.
req_addr  in  $clog2(NUM_CTRS)  counter index.
req_ready  out  1  request accepted when req_valid && req_ready.
rsp_valid  out  1  response valid.
rsp_data  out  CTR_W  counter value.
rsp_ovf  out  1  sticky overflow flag of the addressed counter.
rsp_ready  in  1  response consumed.

Behaviour:
- Reset (async): all counters, shadows and ovf = 0; rsp_valid = 0, rsp_data = 0, rsp_ovf = 0, snap_done = 0.
- Counter update, per cycle: next = cnt + inc_amt (zero-extended) when enable = 1.
  - Overflow when the true sum exceeds 2^CTR_W - 1: set ovf[i] (sticky).
  - SATURATE = 0: result wraps modulo 2^CTR_W. SATURATE = 1: result = all-ones.
- clear has priority over the increment in the same cycle: counter = 0, ovf = 0, increment dropped.
- clear together with snap_req: the shadow captures 0.
- Snapshot: on snap_req, shadow[i] <= value of cnt[i] before this cycle's update, for all i in the same edge; snap_done pulses the next cycle.
  - snap_req while a response is pending is still honoured; the held rsp_data does not change.
- Read FSM states: IDLE, RESP.
  - IDLE: req_ready = 1. On accept, register rsp_data = shadow[req_addr] and rsp_ovf = ovf[req_addr]; go to RESP.
  - RESP: rsp_valid = 1, req_ready = 0, data held stable. On rsp_ready go to IDLE; the next accept is possible in the following cycle.
  - Latency: request accept to rsp_valid = 1 cycle. Throughput is 1 read per 2 cycles.
- req_addr >= NUM_CTRS: rsp_data = 0, rsp_ovf = 0, normal handshake.
- clear in RESP: the held response is unchanged.
- reset mid-transaction: returns to IDLE and drops the response.
- Counters never stall on the read path.

Optional Feature:
VX_PERF_SNAPSHOT_EN.
- Defined: shadow registers and snapshot logic as above; reads return shadow values.
- Undefined: no shadow registers. Reads sample the live counter at accept (pre-update value); snap_req is ignored and snap_done is tied to 0.

Decomposition:
- Package vx_perf_pkg: PERF_CTR_BITS; enum of counter indices (SCHED_IDLES, SCHED_STALLS, IBF_STALLS, NOCU_STALLS, RF_READS, RF_WRITES, REORDERS, IFETCHES, LOADS, STORES, IFETCH_LATENCY, LOAD_LATENCY); read FSM state typedef.
- One sub-module, vx_perf_ctr: a single counter with increment, clear, overflow flag and SATURATE mode, instantiated NUM_CTRS times via generate.

Test Plan:
- Reset, then inc_amt[3] = 5 for 4 cycles, snap_req, read addr 3 -> rsp_data = 20, rsp_ovf = 0, one-cycle latency.
- SATURATE = 0, CTR_W = 8: preload to 250, inc 10 -> cnt = 4, ovf = 1. SATURATE = 1: cnt = 255, ovf = 1, stays 255 after further incs.
- clear and inc 7 on ctr 0 in the same cycle -> cnt 0, ovf 0. snap_req in that cycle -> shadow 0.
- Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready = 0. Then rsp_ready = 1 -> IDLE; req_ready = 1 the next cycle.
- req_addr = NUM_CTRS (12) -> rsp_data = 0 after 1 cycle. Assert reset mid-RESP -> rsp_valid drops immediately (async).
- Without VX_PERF_SNAPSHOT_EN: inc 2/cycle on ctr 5 for 10 cycles, read -> 20 with no snap_req; snap_done never asserts.
